// File: rtl/alu_md_controller.sv
// alu_md_controller
//   ALU operation decode for the EX stage plus an iterative RV32M/RV64M
//   multiply/divide engine. The base ALU decode is purely combinational;
//   M-extension ops are handed to a one-bit-per-cycle engine and the
//   controller raises md_busy so the hazard unit stalls IF/ID/EX.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-low reset
//   ALUOp      00 LW/SW/AUIPC, 01 branch, 10 R/I-type, 11 JAL/JALR/LUI
//   Funct7     instr[31:25]
//   Funct3     instr[14:12]
//   IsRType    1 = R-type; gates the M decode
//   Operation  ALU/MD operation select (bit 4 set = M op), combinational
//   in_valid   EX presents an M op with operands
//   in_ready   engine can accept (idle and out of reset)
//   flush      abort any in-flight M op
//   SrcA/SrcB  rs1/rs2 values
//   out_valid  md_result valid, held until out_ready
//   out_ready  consumer takes the result
//   md_result  M op result
//   md_busy    stall request to the hazard unit
//   dbg_state  current engine state (IDLE=0, CALC=1, FIXUP=2, DONE=3)
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. Once out_valid rises it stays high, with md_result unchanged,
// until that transfer (or a flush/reset). in_ready only depends on the
// engine state, never on in_valid.
module alu_md_controller #(
  parameter int XLEN = 32,
  parameter int OP_W = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [1:0]      ALUOp,
  input  logic [6:0]      Funct7,
  input  logic [2:0]      Funct3,
  input  logic            IsRType,
  output logic [OP_W-1:0] Operation,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            flush,
  input  logic [XLEN-1:0] SrcA,
  input  logic [XLEN-1:0] SrcB,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] md_result,
  output logic            md_busy,
  output logic [1:0]      dbg_state
);

  localparam int CNT_W = $clog2(XLEN);
  localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MD   = 7'b0000001;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CALC  = 2'd1,
    ST_FIXUP = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // ---------------------------------------------------------------------
  // Operation decode
  // ---------------------------------------------------------------------
  logic [4:0] w_op5;

  always_comb begin
    w_op5 = 5'b00000;
    case (ALUOp)
      2'b00: w_op5 = 5'b00010;                               // address add
      2'b01: begin
        case (Funct3)
          3'b000:  w_op5 = 5'b01000;                         // BEQ
          3'b001:  w_op5 = 5'b01010;                         // BNE
          3'b100:  w_op5 = 5'b01011;                         // BLT
          3'b101:  w_op5 = 5'b01100;                         // BGE
          default: w_op5 = 5'b00000;
        endcase
      end
      2'b10: begin
        case (Funct3)
          3'b000:  w_op5 = (Funct7 == F7_ALT) ? 5'b00011 : 5'b00010;
          3'b001:  w_op5 = (Funct7 == F7_BASE) ? 5'b00101 : 5'b00000;
          3'b010:  w_op5 = (Funct7 == F7_BASE) ? 5'b00111 : 5'b00000;
          3'b100:  w_op5 = (Funct7 == F7_BASE) ? 5'b00100 : 5'b00000;
          3'b101: begin
            if (Funct7 == F7_BASE)     w_op5 = 5'b00110;     // SRL
            else if (Funct7 == F7_ALT) w_op5 = 5'b01001;     // SRA
            else                       w_op5 = 5'b00000;
          end
          3'b110:  w_op5 = 5'b00001;                         // OR
          3'b111:  w_op5 = 5'b00000;                         // AND
          default: w_op5 = 5'b00000;                         // SLTU not mapped
        endcase
      end
      default: w_op5 = (Funct3 == 3'b000) ? 5'b01111 : 5'b01101;  // JALR / JAL
    endcase
    // M ops only exist on true R-type encodings; an I-type immediate whose
    // top bits happen to read 0000001 must still decode as the base op.
    if (ALUOp == 2'b10 && IsRType && Funct7 == F7_MD)
      w_op5 = {2'b10, Funct3};
  end

  assign Operation = OP_W'(w_op5);

  // ---------------------------------------------------------------------
  // Operand conditioning at accept
  // ---------------------------------------------------------------------
  logic            w_accept;
  logic            w_a_signed;
  logic            w_b_signed;
  logic            w_neg_a;
  logic            w_neg_b;
  logic [XLEN-1:0] w_abs_a;
  logic [XLEN-1:0] w_abs_b;
  logic            w_div_zero;
  logic            w_div_ovf;
  logic            w_special;

  // Flush beats a simultaneous accept.
  assign w_accept   = in_valid && in_ready && w_op5[4] && !flush;

  // Signed rs1: MUL/MULH/MULHSU, DIV, REM. Signed rs2: MUL/MULH, DIV, REM.
  assign w_a_signed = Funct3[2] ? !Funct3[0] : (Funct3[1:0] != 2'b11);
  assign w_b_signed = Funct3[2] ? !Funct3[0] : !Funct3[1];
  assign w_neg_a    = w_a_signed && SrcA[XLEN-1];
  assign w_neg_b    = w_b_signed && SrcB[XLEN-1];
  assign w_abs_a    = w_neg_a ? -SrcA : SrcA;
  assign w_abs_b    = w_neg_b ? -SrcB : SrcB;

  assign w_div_zero = Funct3[2] && (SrcB == '0);
  assign w_div_ovf  = Funct3[2] && !Funct3[0] && (SrcA == SMIN) && (SrcB == '1);
  assign w_special  = w_div_zero || w_div_ovf;

  // ---------------------------------------------------------------------
  // Iteration datapath
  //   r_hi:r_lo is the product for multiplies (r_lo starts as |rs1| and is
  //   shifted out as product bits shift in) and remainder:quotient for
  //   divides (r_lo starts as |dividend| and quotient bits shift in).
  //   r_b holds |rs2|, the multiplicand or the divisor.
  // ---------------------------------------------------------------------
  logic [CNT_W-1:0] r_cnt;
  logic [XLEN-1:0]  r_hi;
  logic [XLEN-1:0]  r_lo;
  logic [XLEN-1:0]  r_b;
  logic [2:0]       r_f3;
  logic             r_neg_a;
  logic             r_neg_b;

  logic [XLEN:0]    w_mul_sum;
  logic [XLEN:0]    w_div_shift;
  logic [XLEN:0]    w_div_diff;

  assign w_mul_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
  assign w_div_shift = {r_hi, r_lo[XLEN-1]};
  // A set top bit means the trial subtraction went negative (restore).
  assign w_div_diff  = w_div_shift - {1'b0, r_b};

  // Sign fix-up and result select
  logic [2*XLEN-1:0] w_prod;
  logic [2*XLEN-1:0] w_prod_s;
  logic [XLEN-1:0]   w_quo_s;
  logic [XLEN-1:0]   w_rem_s;
  logic [XLEN-1:0]   w_fix_result;

  always_comb begin
    w_prod       = {r_hi, r_lo};
    w_prod_s     = (r_neg_a ^ r_neg_b) ? -w_prod : w_prod;
    w_quo_s      = (r_neg_a ^ r_neg_b) ? -r_lo : r_lo;
    w_rem_s      = r_neg_a ? -r_hi : r_hi;
    w_fix_result = '0;
    case (r_f3)
      3'b000:                 w_fix_result = w_prod_s[XLEN-1:0];
      3'b001, 3'b010, 3'b011: w_fix_result = w_prod_s[2*XLEN-1:XLEN];
      3'b100, 3'b101:         w_fix_result = w_quo_s;
      default:                w_fix_result = w_rem_s;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt     <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_b       <= '0;
      r_f3      <= '0;
      r_neg_a   <= 1'b0;
      r_neg_b   <= 1'b0;
      md_result <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_f3  <= Funct3;
            r_cnt <= CNT_W'(XLEN - 1);
            r_b   <= w_abs_b;
            if (w_div_zero) begin
              // Preload the architectural answer; FIXUP passes it through.
              r_lo    <= '1;
              r_hi    <= SrcA;
              r_neg_a <= 1'b0;
              r_neg_b <= 1'b0;
            end else if (w_div_ovf) begin
              r_lo    <= SrcA;
              r_hi    <= '0;
              r_neg_a <= 1'b0;
              r_neg_b <= 1'b0;
            end else begin
              r_lo    <= w_abs_a;
              r_hi    <= '0;
              r_neg_a <= w_neg_a;
              r_neg_b <= w_neg_b;
            end
          end
        end
        ST_CALC: begin
          if (r_f3[2]) begin
            if (!w_div_diff[XLEN]) begin
              r_hi <= w_div_diff[XLEN-1:0];
              r_lo <= {r_lo[XLEN-2:0], 1'b1};
            end else begin
              r_hi <= w_div_shift[XLEN-1:0];
              r_lo <= {r_lo[XLEN-2:0], 1'b0};
            end
          end else begin
            r_hi <= w_mul_sum[XLEN:1];
            r_lo <= {w_mul_sum[0], r_lo[XLEN-1:1]};
          end
          if (r_cnt != '0)
            r_cnt <= r_cnt - CNT_W'(1);
        end
        ST_FIXUP: begin
          if (!flush)
            md_result <= w_fix_result;
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    md_busy     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        in_ready = reset;
        if (w_accept)
          w_state_nxt = w_special ? ST_FIXUP : ST_CALC;
      end
      ST_CALC: begin
        if (r_cnt == '0)
          w_state_nxt = ST_FIXUP;
      end
      ST_FIXUP: w_state_nxt = ST_DONE;
      default: begin
        out_valid = 1'b1;
        if (out_ready)
          w_state_nxt = ST_IDLE;
      end
    endcase
    // Stall as soon as an M op shows up, before it is even accepted.
    md_busy = reset && ((r_state != ST_IDLE) || (in_valid && w_op5[4]));
    if (flush)
      w_state_nxt = ST_IDLE;
  end

  assign dbg_state = r_state;

endmodule

// File: tb/tb_alu_md_controller.sv
module tb_alu_md_controller;

  localparam int XLEN = 32;
  localparam int OP_W = 5;
  localparam logic [31:0] SMIN = 32'h8000_0000;
  localparam int LAT_CALC = XLEN + 1;   // out_valid sampled at edge accept+XLEN+2
  localparam int LAT_FAST = 1;          // out_valid sampled at edge accept+2
  localparam int WAIT_MAX = 300;

  // ---------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------
  logic            clk = 1'b0;
  logic            reset;
  logic [1:0]      ALUOp;
  logic [6:0]      Funct7;
  logic [2:0]      Funct3;
  logic            IsRType;
  logic [OP_W-1:0] Operation;
  logic            in_valid;
  logic            in_ready;
  logic            flush;
  logic [XLEN-1:0] SrcA;
  logic [XLEN-1:0] SrcB;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] md_result;
  logic            md_busy;
  logic [1:0]      dbg_state;

  always #5 clk = ~clk;

  alu_md_controller #(.XLEN(XLEN), .OP_W(OP_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .ALUOp     (ALUOp),
    .Funct7    (Funct7),
    .Funct3    (Funct3),
    .IsRType   (IsRType),
    .Operation (Operation),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .flush     (flush),
    .SrcA      (SrcA),
    .SrcB      (SrcB),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .md_result (md_result),
    .md_busy   (md_busy),
    .dbg_state (dbg_state)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out after %0d cycles", name, WAIT_MAX);
  endtask

  // ---------------------------------------------------------------------
  // Reference models
  // ---------------------------------------------------------------------
  function automatic logic [4:0] exp_op(input logic [1:0] aluop, input logic [6:0] f7,
                                        input logic [2:0] f3, input logic isr);
    bit plain = (f7 == 7'b0000000);
    bit alt   = (f7 == 7'b0100000);
    if (aluop == 2'b10 && isr && f7 == 7'b0000001) return {2'b10, f3};
    if (aluop == 2'b00) return 5'b00010;
    if (aluop == 2'b11) return (f3 == 3'b000) ? 5'b01111 : 5'b01101;
    if (aluop == 2'b01) begin
      if (f3 == 3'd0) return 5'b01000;
      if (f3 == 3'd1) return 5'b01010;
      if (f3 == 3'd4) return 5'b01011;
      if (f3 == 3'd5) return 5'b01100;
      return 5'b00000;
    end
    if (f3 == 3'd0) return alt ? 5'b00011 : 5'b00010;
    if (f3 == 3'd1 && plain) return 5'b00101;
    if (f3 == 3'd2 && plain) return 5'b00111;
    if (f3 == 3'd4 && plain) return 5'b00100;
    if (f3 == 3'd5 && plain) return 5'b00110;
    if (f3 == 3'd5 && alt)   return 5'b01001;
    if (f3 == 3'd6)          return 5'b00001;
    return 5'b00000;
  endfunction

  function automatic logic [31:0] md_model(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] b);
    longint sa = longint'(signed'(a));
    longint sb = longint'(signed'(b));
    longint sp;
    logic [63:0] up;
    case (f3)
      3'd0: begin sp = sa * sb; return sp[31:0]; end
      3'd1: begin sp = sa * sb; return sp[63:32]; end
      3'd2: begin sp = sa * longint'({32'b0, b}); return sp[63:32]; end
      3'd3: begin up = {32'b0, a} * {32'b0, b}; return up[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == SMIN && b == 32'hFFFF_FFFF) return a;
        sp = sa / sb; return sp[31:0];
      end
      3'd5: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        return a / b;
      end
      3'd6: begin
        if (b == 32'd0) return a;
        if (a == SMIN && b == 32'hFFFF_FFFF) return 32'd0;
        sp = sa % sb; return sp[31:0];
      end
      default: begin
        if (b == 32'd0) return a;
        return a % b;
      end
    endcase
  endfunction

  function automatic int md_latency(input logic [2:0] f3, input logic [31:0] a,
                                    input logic [31:0] b);
    if (f3[2] && b == 32'd0) return LAT_FAST;
    if (f3[2] && !f3[0] && a == SMIN && b == 32'hFFFF_FFFF) return LAT_FAST;
    return LAT_CALC;
  endfunction

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 5))
      0: return $urandom();
      1: return 32'd0;
      2: return 32'hFFFF_FFFF;
      3: return SMIN;
      4: return 32'($urandom_range(0, 20));
      default: return -32'($urandom_range(1, 20));
    endcase
  endfunction

  // ---------------------------------------------------------------------
  // Scoreboard and monitor
  // ---------------------------------------------------------------------
  logic [XLEN-1:0] exp_q[$];
  int              acc_q[$];
  int              lat_q[$];

  bit              mon_active = 1'b0;
  logic [XLEN-1:0] cur_res;
  int              cur_acc;
  int              cur_lat;

  always @(negedge clk) begin
    if (reset === 1'b1 && out_valid === 1'b1) begin
      if (!mon_active) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out_valid: got md_result %0h, expected no result", md_result);
        end else begin
          cur_res    = exp_q.pop_front();
          cur_acc    = acc_q.pop_front();
          cur_lat    = lat_q.pop_front();
          mon_active = 1'b1;
          check("latency", 64'(cyc - cur_acc), 64'(cur_lat));
        end
      end
      if (mon_active) begin
        check("md_result", 64'(md_result), 64'(cur_res));
        if (out_ready) mon_active = 1'b0;
      end
    end
  end

  // Consumer back-pressure: random unless a test pins it low.
  bit hold_rdy = 1'b0;
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      out_ready = hold_rdy ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  // ---------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------
  task automatic set_m_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    ALUOp   = 2'b10;
    IsRType = 1'b1;
    Funct7  = 7'b0000001;
    Funct3  = f3;
    SrcA    = a;
    SrcB    = b;
  endtask

  // Presents one M op for a single accept edge. When track is set the
  // expected result and latency are queued for the monitor.
  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] e, input int lat, input bit track);
    int n = 0;
    @(negedge clk);
    while (in_ready !== 1'b1 && n < WAIT_MAX) begin
      @(negedge clk);
      n++;
    end
    if (n >= WAIT_MAX) timeout_fail("in_ready_wait");
    set_m_op(f3, a, b);
    in_valid = 1'b1;
    if (track) begin
      exp_q.push_back(e);
      acc_q.push_back(cyc + 1);
      lat_q.push_back(lat);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while ((exp_q.size() != 0 || mon_active) && n < WAIT_MAX) begin
      @(negedge clk);
      n++;
    end
    if (n >= WAIT_MAX) timeout_fail("result_wait");
  endtask

  task automatic run_md(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] e, input int lat);
    issue(f3, a, b, e, lat, 1'b1);
    wait_done();
  endtask

  task automatic chk_decode(input string name, input logic [1:0] aluop, input logic [6:0] f7,
                            input logic [2:0] f3, input logic isr, input logic [4:0] e);
    @(negedge clk);
    ALUOp   = aluop;
    Funct7  = f7;
    Funct3  = f3;
    IsRType = isr;
    #1;
    check(name, 64'(Operation), 64'(e));
  endtask

  // ---------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------
  initial begin
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  aluop;
    logic [6:0]  f7;
    logic        isr;
    int          n;

    reset    = 1'b1;
    ALUOp    = 2'b00;
    Funct7   = 7'd0;
    Funct3   = 3'd0;
    IsRType  = 1'b0;
    in_valid = 1'b0;
    flush    = 1'b0;
    SrcA     = '0;
    SrcB     = '0;
    #1 reset = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_md_busy",   64'(md_busy),   64'd0);
    check("rst_in_ready",  64'(in_ready),  64'd0);
    check("rst_md_result", 64'(md_result), 64'd0);
    reset = 1'b1;
    @(negedge clk);
    check("rel_in_ready",  64'(in_ready),  64'd1);
    check("rel_md_busy",   64'(md_busy),   64'd0);
    check("rel_out_valid", 64'(out_valid), 64'd0);

    // Decode: directed points then a random sweep
    chk_decode("dec_blt",  2'b01, 7'b0000000, 3'b100, 1'b1, 5'b01011);
    chk_decode("dec_sra",  2'b10, 7'b0100000, 3'b101, 1'b1, 5'b01001);
    chk_decode("dec_jalr", 2'b11, 7'b0000000, 3'b000, 1'b0, 5'b01111);
    chk_decode("dec_addi", 2'b10, 7'b0000001, 3'b000, 1'b0, 5'b00010);
    chk_decode("dec_divu", 2'b10, 7'b0000001, 3'b101, 1'b1, 5'b10101);
    chk_decode("dec_sub",  2'b10, 7'b0100000, 3'b000, 1'b1, 5'b00011);
    chk_decode("dec_badsll", 2'b10, 7'b0100000, 3'b001, 1'b1, 5'b00000);
    for (int i = 0; i < 60; i++) begin
      aluop = 2'($urandom_range(0, 3));
      f3    = 3'($urandom_range(0, 7));
      isr   = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0: f7 = 7'b0000000;
        1: f7 = 7'b0100000;
        2: f7 = 7'b0000001;
        default: f7 = 7'($urandom_range(0, 127));
      endcase
      chk_decode("dec_rand", aluop, f7, f3, isr, exp_op(aluop, f7, f3, isr));
    end

    // Directed multiply/divide
    run_md(3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, LAT_CALC);           // MUL
    run_md(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, LAT_CALC);   // MULHU
    run_md(3'b101, 32'd100, 32'd7, 32'd14, LAT_CALC);                        // DIVU
    run_md(3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, LAT_CALC);           // REM
    run_md(3'b100, SMIN, 32'hFFFF_FFFF, SMIN, LAT_FAST);                     // DIV ovf
    run_md(3'b100, 32'd5, 32'd0, 32'hFFFF_FFFF, LAT_FAST);                   // DIV /0
    run_md(3'b111, 32'd5, 32'd0, 32'd5, LAT_FAST);                           // REMU /0
    run_md(3'b110, SMIN, 32'hFFFF_FFFF, 32'd0, LAT_FAST);                    // REM ovf

    // Random operations against the model
    for (int i = 0; i < 40; i++) begin
      f3 = 3'($urandom_range(0, 7));
      a  = rand_operand();
      b  = rand_operand();
      run_md(f3, a, b, md_model(f3, a, b), md_latency(f3, a, b));
    end

    // Back-pressure hold with an in_valid M op kept up while busy
    hold_rdy = 1'b1;
    issue(3'b000, 32'd12345, 32'd678, md_model(3'b000, 32'd12345, 32'd678), LAT_CALC, 1'b1);
    set_m_op(3'b100, 32'd99, 32'd3);
    in_valid = 1'b1;
    n = 0;
    while (out_valid !== 1'b1 && n < WAIT_MAX) begin
      @(negedge clk);
      n++;
    end
    if (n >= WAIT_MAX) timeout_fail("hold_out_valid");
    for (int i = 0; i < 5; i++) begin
      check("hold_out_valid", 64'(out_valid), 64'd1);
      check("hold_in_ready",  64'(in_ready),  64'd0);
      check("hold_md_busy",   64'(md_busy),   64'd1);
      @(negedge clk);
    end
    in_valid = 1'b0;
    hold_rdy = 1'b0;
    wait_done();

    // Flush during CALC: the result must never appear
    issue(3'b001, $urandom(), $urandom(), 32'd0, 0, 1'b0);
    repeat (9) @(negedge clk);
    check("flush_busy_before", 64'(md_busy), 64'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_in_ready",  64'(in_ready),  64'd1);
    check("flush_out_valid", 64'(out_valid), 64'd0);
    check("flush_md_busy",   64'(md_busy),   64'd0);
    repeat (XLEN + 5) @(negedge clk);
    check("flush_quiet", 64'(out_valid), 64'd0);

    // Flush in the same cycle as an accept attempt wins
    @(negedge clk);
    set_m_op(3'b000, 32'd3, 32'd4);
    in_valid = 1'b1;
    flush    = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    flush    = 1'b0;
    #1;
    check("flushacc_in_ready", 64'(in_ready), 64'd1);
    check("flushacc_md_busy",  64'(md_busy),  64'd0);
    repeat (XLEN + 5) @(negedge clk);

    // Asynchronous reset in the middle of CALC
    issue(3'b101, 32'd1000, 32'd3, 32'd0, 0, 1'b0);
    repeat (8) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("arst_out_valid", 64'(out_valid), 64'd0);
    check("arst_md_result", 64'(md_result), 64'd0);
    check("arst_md_busy",   64'(md_busy),   64'd0);
    check("arst_in_ready",  64'(in_ready),  64'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("arel_in_ready",  64'(in_ready),  64'd1);
    check("arel_md_busy",   64'(md_busy),   64'd0);
    check("arel_out_valid", 64'(out_valid), 64'd0);

    // Engine still works after reset
    run_md(3'b010, 32'hFFFF_FFFE, 32'h8000_0001, md_model(3'b010, 32'hFFFF_FFFE, 32'h8000_0001),
           LAT_CALC);

    repeat (5) @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_md_controller.md
Name: alu_md_controller

Overview:
- Next-generation ALU controller. Keeps the ALUOp/Funct3/Funct7 decode and extends it to RV32M/RV64M MUL/DIV/REM.
- The base decode stays combinational. M-extension ops run on an internal iterative multiply/divide engine with valid/ready handshakes.
- Sits in EX beside the ALU. Its busy signal stalls IF/ID/EX while an M op is in flight.

Parameters:
- XLEN, 32, operand/result width (32 or 64).
- OP_W, 5, Operation width. Must be ≥5; bit 4 marks M ops.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- ALUOp  in  2  00 LW/SW/AUIPC, 01 branch, 10 R/I-type, 11 JAL/JALR/LUI
- Funct7  in  7  instr[31:25]
- Funct3  in  3  instr[14:12]
- IsRType  in  1  1 = R-type (opcode 0110011); gates M decode
- Operation  out  OP_W  ALU/MD operation select, combinational
- in_valid  in  1  EX presents an M op with operands
- in_ready  out  1  engine can accept
- flush  in  1  abort in-flight M op (branch mispredict)
- SrcA  in  XLEN  rs1 value
- SrcB  in  XLEN  rs2 value
- out_valid  out  1  md_result valid; held until out_ready
- out_ready  in  1  consumer takes the result
- md_result  out  XLEN  M op result
- md_busy  out  1  stall request to the hazard unit

Behaviour:
- Base decode, combinational, zero-extended to OP_W:
  - AND 00000, OR 00001, LW/SW/ADD/ADDI 00010, SUB 00011, XOR 00100, SLL 00101, SRL 00110, SLT 00111.
  - SRA 01001, BEQ 01000, BNE 01010, BLT 01011, BGE 01100, JAL 01101, JALR (ALUOp=11, Funct3=000) 01111.
  - SUB and SRA require Funct7=0100000. SLL/SRL/SLT/XOR require Funct7=0000000.
  - Any undecoded combination gives 00000.
- M decode: ALUOp=10, IsRType=1, Funct7=0000001 → Operation = {1,0,Funct3}.
  - MUL 10000, MULH 10001, MULHSU 10010, MULHU 10011, DIV 10100, DIVU 10101, REM 10110, REMU 10111.
  - Takes priority over base decode.
- FSM states: IDLE, CALC, FIXUP, DONE.
  - in_ready = (state==IDLE) and not reset.
  - md_busy = (state!=IDLE) or (in_valid and Operation[4]).
- Accept: in_valid & in_ready & Operation[4] at edge N.
  - Latch SrcA, SrcB and Funct3. Take absolute values per signedness.
  - Load counter = XLEN-1. Go to CALC.
  - in_valid with a non-M Operation is ignored.
- CALC, one bit per cycle:
  - Multiply: shift-add, 2·XLEN-bit product.
  - Divide: restoring; quotient and remainder, XLEN bits each.
  - Counter reaching 0 → FIXUP.
- FIXUP: apply sign.
  - Product is negated if the operand signs differ (MULHSU: SrcA sign only).
  - Quotient is negated if the signs differ. Remainder takes the dividend's sign.
  - Select output: MUL low half; MULH/MULHSU/MULHU high half.
  - Register md_result and go to DONE.
- DONE: out_valid=1; md_result stable. out_valid & out_ready → IDLE.
- Latency: out_valid first high at edge N+XLEN+2 (34 cycles for XLEN=32).
- Special cases bypass CALC (accept → FIXUP → DONE, out_valid at N+2):
  - Divide by zero: DIV/DIVU quotient = all ones; REM/REMU = SrcA.
  - Signed overflow (SrcA = −2^(XLEN−1), SrcB = −1): DIV = SrcA; REM = 0.
- flush: from any state → IDLE next edge. out_valid drops; the result is discarded. flush in the same cycle as accept wins (no accept).
- Reset, asynchronous, active-low, including mid-operation:
  - state=IDLE; counter, operands, accumulators and md_result = 0.
  - out_valid=0, md_busy=0, in_ready=1 after release.
- A new accept is not possible before DONE is consumed. Back-to-back ops: the next accept comes at the earliest one cycle after the handshake.

Test Plan:
- Decode sweep: ALUOp=01 with Funct3=100 → 01011. ALUOp=10, Funct3=101, Funct7=0100000 → 01001. ALUOp=11, Funct3=000 → 01111. ALUOp=10, IsRType=0, Funct7=0000001, Funct3=000 → 00010 (ADDI, not MUL).
- MUL: SrcA=7, SrcB=0xFFFFFFFD → md_result=0xFFFFFFEB, out_valid at accept+34. MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
- Division: DIVU 100/7 → 14. REM −7 (0xFFFFFFF9) % 2 → 0xFFFFFFFF. DIV 0x80000000/−1 → 0x80000000 at accept+2.
- Divide by zero: DIV 5/0 → 0xFFFFFFFF. REMU 5/0 → 5. Both at accept+2.
- Handshake: hold out_ready=0 for 5 cycles → out_valid and md_result stable, md_busy=1, in_ready=0. Drop in-flight in_valid while busy → no new accept.
- flush at CALC cycle 10 → IDLE next edge, no out_valid. Assert reset low mid-CALC → all outputs 0 immediately, in_ready=1 after release.
